result_bus_arbiter: RTL

//  Collects finished results from up to UNITS execution-unit wrappers (log, add, mul, ...).

---
 rtl/result_bus_arbiter_pkg.sv | 19 +
 rtl/result_bus_arbiter_rr.sv | 27 ++
 rtl/result_bus_arbiter.sv | 60 ++++++
 3 files changed

// File: rtl/result_bus_arbiter_pkg.sv
// result_bus_arbiter_pkg: shared result-bus types and round-robin helper
package result_bus_arbiter_pkg;
  localparam int RS_ID_W = 5;
  typedef struct packed {
    logic [0:3] cr0;
    logic       so;
    logic       ov;
    logic       ca;
  } cond_exception_t;
  typedef struct packed {
    logic [0:RS_ID_W-1] rs_id;
    logic [0:4]         reg_addr;
    logic [0:31]        result;
    cond_exception_t    cr0_xer;
  } result_bus_t;
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction
endpackage

// File: rtl/result_bus_arbiter_rr.sv
// rr_arbiter: round-robin grant over req, priority pointer moves past the winner on advance
module rr_arbiter
  import result_bus_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [0:N-1]         req,
  input  logic                 advance,
  output logic [0:N-1]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] ptr;
  // scan from the farthest offset down so the nearest requester to ptr wins
  always_comb begin
    grant = '0;
    grant_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) grant_idx = IW'((int'(ptr) + k) % N);
    grant[grant_idx] = |req;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= '0;
    else if (advance) ptr <= IW'(rr_next(int'(grant_idx), N));
endmodule

// File: rtl/result_bus_arbiter.sv
// result_bus_arbiter: round-robin collection of unit results onto one registered result bus
module result_bus_arbiter
  import result_bus_arbiter_pkg::*;
#(
  parameter int UNITS       = 4,
  parameter int RS_ID_WIDTH = RS_ID_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [0:UNITS-1]                   in_valid,
  output logic [0:UNITS-1]                   in_ready,
  input  logic [0:UNITS-1][0:RS_ID_WIDTH-1]  in_rs_id,
  input  logic [0:UNITS-1][0:4]              in_reg_addr,
  input  logic [0:UNITS-1][0:31]             in_result,
  input  cond_exception_t [0:UNITS-1]        in_cr0_xer,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [0:RS_ID_WIDTH-1]             out_rs_id,
  output logic [0:4]                         out_reg_addr,
  output logic [0:31]                        out_result,
  output cond_exception_t                    out_cr0_xer,
  output logic [$clog2(UNITS)-1:0]           out_unit
);
  logic [0:UNITS-1]         grant;
  logic [$clog2(UNITS)-1:0] grant_idx;
  logic                     can_load;
  logic                     load;
  result_bus_t              bus;
  // rst gates readiness so nothing is accepted while reset is held
  assign can_load = rst && (!out_valid || out_ready);
  assign in_ready = can_load ? grant : '0;
  assign load     = |(in_valid & in_ready);
  rr_arbiter #(.N(UNITS)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (load),
    .grant     (grant),
    .grant_idx (grant_idx)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid <= 1'b0;
      out_unit  <= '0;
      bus       <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_unit  <= grant_idx;
      bus       <= '{rs_id:    in_rs_id[grant_idx],
                     reg_addr: in_reg_addr[grant_idx],
                     result:   in_result[grant_idx],
                     cr0_xer:  in_cr0_xer[grant_idx]};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  assign out_rs_id    = bus.rs_id;
  assign out_reg_addr = bus.reg_addr;
  assign out_result   = bus.result;
  assign out_cr0_xer  = bus.cr0_xer;
endmodule
